// File: rtl/uart_monitor.sv
// Boot/debug monitor: parses W/R/G commands from the UART to write, read back and start from program RAM,
// and hands RAM and UART to the CPU while it runs. All monitor outputs are registered; the ownership mux is combinational.
module uart_monitor (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       received,
  input  logic       is_transmitting,
  output logic [7:0] tx_byte,
  output logic       transmit,
  input  logic [7:0] dread,
  output logic [8:0] raddr,
  output logic [8:0] waddr,
  output logic [7:0] dwrite,
  output logic       write_en,
  input  logic [8:0] c_raddr,
  input  logic [8:0] c_waddr,
  input  logic [7:0] c_dwrite,
  input  logic       c_write_en,
  input  logic [7:0] c_tx_byte,
  input  logic       c_transmit,
  output logic       c_received,
  output logic       cpu_start,
  output logic [8:0] startaddr,
  input  logic       cpu_halted,
  output logic       cpu_owns
);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] ACK   = 8'h2E;
  localparam logic [7:0] DONE  = 8'h21;
  localparam logic [7:0] NAK   = 8'h3F;

  typedef enum logic [3:0] {
    IDLE, ADDRH, ADDRL, LEN, WDATA, RADDR, RWAIT, RDATA, RTX, GO, RUN, REPLY
  } state_t;

  state_t     state;
  logic [7:0] cmd;
  logic [8:0] addr;
  logic [8:0] count;
  logic [7:0] reply;
  logic [7:0] rbyte;
  logic [7:0] m_tx_byte;
  logic       m_transmit;
  logic [8:0] m_raddr;
  logic [8:0] m_waddr;
  logic [7:0] m_dwrite;
  logic       m_write_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cmd        <= 8'h00;
      addr       <= 9'h000;
      count      <= 9'h000;
      reply      <= 8'h00;
      rbyte      <= 8'h00;
      m_tx_byte  <= 8'h00;
      m_transmit <= 1'b0;
      m_raddr    <= 9'h000;
      m_waddr    <= 9'h000;
      m_dwrite   <= 8'h00;
      m_write_en <= 1'b0;
      cpu_start  <= 1'b0;
      startaddr  <= 9'h000;
      cpu_owns   <= 1'b0;
    end else begin
      m_transmit <= 1'b0;
      m_write_en <= 1'b0;
      cpu_start  <= 1'b0;
      case (state)
        IDLE: if (received) begin
          if (rx_byte == CMD_W || rx_byte == CMD_R || rx_byte == CMD_G) begin
            cmd   <= rx_byte;
            state <= ADDRH;
          end else begin
            reply <= NAK;
            state <= REPLY;
          end
        end
        ADDRH: if (received) begin
          addr[8] <= rx_byte[0];
          state   <= ADDRL;
        end
        ADDRL: if (received) begin
          addr[7:0] <= rx_byte;
          state     <= (cmd == CMD_G) ? GO : LEN;
        end
        // A length byte of 0 encodes 256 via the ninth count bit.
        LEN: if (received) begin
          count <= {(rx_byte == 8'h00), rx_byte};
          state <= (cmd == CMD_W) ? WDATA : RADDR;
        end
        WDATA: if (received) begin
          m_write_en <= 1'b1;
          m_waddr    <= addr;
          m_dwrite   <= rx_byte;
          addr       <= addr + 9'd1;
          count      <= count - 9'd1;
          if (count == 9'd1) begin
            reply <= ACK;
            state <= REPLY;
          end
        end
        RADDR: begin
          m_raddr <= addr;
          state   <= RWAIT;
        end
        RWAIT: state <= RDATA;
        RDATA: begin
          rbyte <= dread;
          state <= RTX;
        end
        RTX: if (!is_transmitting) begin
          m_transmit <= 1'b1;
          m_tx_byte  <= rbyte;
          addr       <= addr + 9'd1;
          count      <= count - 9'd1;
          state      <= (count == 9'd1) ? IDLE : RADDR;
        end
        GO: begin
          startaddr <= addr;
          cpu_owns  <= 1'b1;
          cpu_start <= 1'b1;
          state     <= RUN;
        end
        RUN: if (cpu_halted) begin
          cpu_owns <= 1'b0;
          reply    <= DONE;
          state    <= REPLY;
        end
        REPLY: if (!is_transmitting) begin
          m_transmit <= 1'b1;
          m_tx_byte  <= reply;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tx_byte    = cpu_owns ? c_tx_byte  : m_tx_byte;
  assign transmit   = cpu_owns ? c_transmit : m_transmit;
  assign raddr      = cpu_owns ? c_raddr    : m_raddr;
  assign waddr      = cpu_owns ? c_waddr    : m_waddr;
  assign dwrite     = cpu_owns ? c_dwrite   : m_dwrite;
  assign write_en   = cpu_owns ? c_write_en : m_write_en;
  assign c_received = cpu_owns & received;

endmodule

// File: tb/tb_uart_monitor.sv
// Directed bench for uart_monitor with a synchronous-read RAM model and a transmit log.
module tb_uart_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_byte;
  logic       received;
  logic       is_transmitting;
  logic [7:0] tx_byte;
  logic       transmit;
  logic [7:0] dread;
  logic [8:0] raddr, waddr;
  logic [7:0] dwrite;
  logic       write_en;
  logic [8:0] c_raddr, c_waddr;
  logic [7:0] c_dwrite;
  logic       c_write_en;
  logic [7:0] c_tx_byte;
  logic       c_transmit;
  logic       c_received;
  logic       cpu_start;
  logic [8:0] startaddr;
  logic       cpu_halted;
  logic       cpu_owns;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [512];
  logic [7:0] txq [$];
  int         wr_cnt = 0;
  int         cs_cnt = 0;
  int         cs_owned = 0;

  uart_monitor dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .received(received),
    .is_transmitting(is_transmitting), .tx_byte(tx_byte), .transmit(transmit),
    .dread(dread), .raddr(raddr), .waddr(waddr), .dwrite(dwrite), .write_en(write_en),
    .c_raddr(c_raddr), .c_waddr(c_waddr), .c_dwrite(c_dwrite), .c_write_en(c_write_en),
    .c_tx_byte(c_tx_byte), .c_transmit(c_transmit), .c_received(c_received),
    .cpu_start(cpu_start), .startaddr(startaddr), .cpu_halted(cpu_halted), .cpu_owns(cpu_owns)
  );

  always #5 clk = ~clk;

  // RAM with one-cycle registered read, plus logs of transmit and cpu_start pulses.
  always @(posedge clk) begin
    if (write_en) begin
      mem[waddr] <= dwrite;
      wr_cnt     <= wr_cnt + 1;
    end
    dread <= mem[raddr];
    if (transmit) txq.push_back(tx_byte);
    if (cpu_start) begin
      cs_cnt <= cs_cnt + 1;
      if (cpu_owns) cs_owned <= cs_owned + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    received = 1'b1;
    @(negedge clk);
    received = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_tx(input string tag, input logic [7:0] exp);
    for (int i = 0; i < 300 && txq.size() == 0; i++) @(negedge clk);
    chk(tag, (txq.size() != 0) ? {24'h0, txq.pop_front()} : 32'h1FFFF, {24'h0, exp});
  endtask

  initial begin
    int w0;
    rst = 1'b1; rx_byte = 8'h00; received = 1'b0; is_transmitting = 1'b0;
    c_raddr = 9'h0; c_waddr = 9'h0; c_dwrite = 8'h0; c_write_en = 1'b0;
    c_tx_byte = 8'h0; c_transmit = 1'b0; cpu_halted = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_strobes", {28'h0, transmit, write_en, cpu_start, cpu_owns}, 32'h0);
    chk("reset_addrs", {5'h0, raddr, waddr, startaddr}, 32'h0);
    chk("reset_data", {16'h0, tx_byte, dwrite}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Write three bytes at 0x110
    send(8'h57); send(8'h01); send(8'h10); send(8'h03);
    send(8'hAA); send(8'hBB);
    chk("w1_no_early_ack", txq.size(), 0);
    send(8'hCC);
    wait_tx("w1_ack", 8'h2E);
    chk("w1_count", wr_cnt, 3);
    chk("w1_data", {8'h0, mem[9'h110], mem[9'h111], mem[9'h112]}, 32'h00AABBCC);

    // Read back with UART busy at first and CPU write enable asserted but not owned
    c_write_en = 1'b1; c_waddr = 9'h110; c_dwrite = 8'hEE;
    is_transmitting = 1'b1;
    send(8'h52); send(8'h01); send(8'h10); send(8'h03);
    repeat (10) @(negedge clk);
    chk("r_wait_busy", txq.size(), 0);
    is_transmitting = 1'b0;
    wait_tx("r_b0", 8'hAA);
    wait_tx("r_b1", 8'hBB);
    wait_tx("r_b2", 8'hCC);
    chk("r_no_write", wr_cnt, 3);
    c_write_en = 1'b0;

    // Hi byte 0xFF uses only bit 0; address wraps past 0x1FF
    send(8'h57); send(8'hFF); send(8'hFF); send(8'h02); send(8'h11); send(8'h22);
    wait_tx("wrap_ack", 8'h2E);
    chk("wrap_data", {16'h0, mem[9'h1FF], mem[9'h000]}, 32'h1122);

    // Go at 0x020, CPU traffic passes through, halt returns control
    send(8'h47); send(8'h00); send(8'h20);
    repeat (3) @(negedge clk);
    chk("go_owns", cpu_owns, 1);
    chk("go_startaddr", startaddr, 9'h020);
    chk("go_start_pulse", {cs_cnt[15:0], cs_owned[15:0]}, 32'h00010001);
    c_write_en = 1'b1; c_waddr = 9'h055; c_dwrite = 8'h77; c_transmit = 1'b1; c_tx_byte = 8'h99;
    #1;
    chk("run_cpu_we", {write_en, 3'h0, waddr, dwrite}, {1'b1, 3'h0, 9'h055, 8'h77});
    chk("run_cpu_tx", {transmit, tx_byte}, {1'b1, 8'h99});
    @(negedge clk);
    c_write_en = 1'b0; c_transmit = 1'b0;
    @(negedge clk);
    txq.delete();
    rx_byte = 8'h57; received = 1'b1;
    #1 chk("run_c_received", c_received, 1);
    @(negedge clk);
    received = 1'b0;
    repeat (2) @(negedge clk);
    chk("run_not_parsed", {cpu_owns, 31'(txq.size())}, 32'h80000000);
    rx_byte = 8'h52; received = 1'b1; cpu_halted = 1'b1;
    #1 chk("halt_c_received", c_received, 1);
    @(negedge clk);
    received = 1'b0; cpu_halted = 1'b0;
    chk("halt_released", cpu_owns, 0);
    wait_tx("halt_done", 8'h21);
    chk("halt_start_once", cs_cnt, 1);

    // Stray byte gets NAK and is not gated to the CPU
    @(negedge clk);
    rx_byte = 8'h41; received = 1'b1;
    #1 chk("idle_gate", c_received, 0);
    @(negedge clk);
    received = 1'b0;
    wait_tx("stray_nak", 8'h3F);

    // Length 0 means 256 bytes
    w0 = wr_cnt;
    send(8'h57); send(8'h00); send(8'h00); send(8'h00);
    for (int i = 0; i < 255; i++) send(8'(i) ^ 8'h5A);
    chk("len0_no_early_ack", txq.size(), 0);
    send(8'hFF ^ 8'h5A);
    wait_tx("len0_ack", 8'h2E);
    chk("len0_count", wr_cnt - w0, 256);
    chk("len0_ends", {16'h0, mem[9'h000], mem[9'h0FF]}, {16'h0, 8'h5A, 8'hA5});

    // Reset in the middle of a write
    send(8'h57); send(8'h00); send(8'h40); send(8'h03); send(8'h01);
    @(negedge clk);
    rx_byte = 8'h02; received = 1'b1;
    @(negedge clk);
    received = 1'b0;
    chk("mid_w_we_high", write_en, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_strobes", {29'h0, write_en, transmit, cpu_owns}, 32'h0);
    chk("rst_async_addrs", {6'h0, waddr, dwrite, raddr}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_kept_byte", mem[9'h040], 8'h01);
    send(8'h57); send(8'h00); send(8'h50); send(8'h01); send(8'hEE);
    wait_tx("post_rst_ack", 8'h2E);
    chk("post_rst_data", mem[9'h050], 8'hEE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
